tmr0_ctrl: RTL and testbench
============================

# tmr0_ctrl

Register-side controller for the TMR0 timer datapath. Holds the OPTION and INTCON timer bits and the 8-bit TMR0 count register, and drives the datapath's configuration and prescaler-clear inputs. Synchronises the datapath's prescaled tick into `clk`, increments TMR0 on each tick edge, and raises T0IF and the interrupt on overflow. Sits between the core's special-function-register bus and the timer datapath.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the tick synchroniser; minimum 2.
- `INHIBIT_CYCLES`, default 2: clk cycles of increment inhibit after a TMR0 write.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: reset, synchronous, active-low.
- `addr` in 2: register select. 0 = TMR0, 1 = OPTION, 2 = INTCON, 3 = unmapped.
- `wr_en` in 1: write strobe, sampled on `clk` rising edge.
- `wr_data` in 8: write data.
- `rd_data` out 8: combinational read of the register selected by `addr`. Unmapped address reads 0.
- `tick_in` in 1: prescaled timer clock from the datapath. Asynchronous to `clk`.
- `t0cs`, `t0se`, `psa` out 1 each: OPTION[5], OPTION[4], OPTION[3] to the datapath.
- `ps` out 3: OPTION[2:0] to the datapath.
- `presc_rst_n` out 1: registered active-low prescaler clear to the datapath.
- `tmr0_val` out 8: current TMR0 count.
- `t0if` out 1: overflow flag, INTCON[2].
- `irq` out 1: `t0if & t0ie & gie`, combinational from registered bits.

## Operation
- Reset values (while `reset` is 0 at a clk edge):
  - OPTION = 8'hFF, so `t0cs`=1, `t0se`=1, `psa`=1, `ps`=3'b111.
  - TMR0 = 8'h00.
  - GIE, T0IE and T0IF = 0, so `irq`=0.
  - `presc_rst_n` = 0.
  - Synchroniser flops and inhibit counter = 0, FSM in RUN.
- INTCON layout: bit7 GIE, bit5 T0IE, bit2 T0IF. Other bits read 0 and ignore writes. OPTION stores all 8 bits; bits 7:6 are unused here.
- Tick path: `tick_in` passes through the SYNC_STAGES synchroniser. The increment event is a rising edge on the synchroniser output (output high, delayed copy low). Only one event per `tick_in` rising edge; falling edges are ignored.
- Counting: each event adds 1 to TMR0, modulo 256. An 8'hFF to 8'h00 wrap sets T0IF. T0IF is sticky until software writes 0 to INTCON[2].
- Prescaler clear: `presc_rst_n` is driven 0 for exactly one clk cycle after:
  - any TMR0 write;
  - an OPTION write that changes bit 3 or bits 2:0.
  Otherwise it is 1.
- FSM states:
  - RUN: increments allowed. A TMR0 write moves to HOLD and loads the inhibit counter with INHIBIT_CYCLES.
  - HOLD: increment events are dropped, not deferred. The counter decrements each cycle; at 1 it returns to RUN. A further TMR0 write in HOLD reloads the counter.
- Simultaneous events:
  - TMR0 write and increment event in the same cycle: the write value wins and the event is dropped.
  - Overflow and an INTCON write clearing T0IF in the same cycle: T0IF ends at 1 (set wins). The other INTCON bits take the written value.
  - Software writing 1 to T0IF sets it.
- Reset mid-operation (including in HOLD): all state returns to reset values at that edge. A tick edge pending in the synchroniser is lost.

## Timing
- Writes take effect at the `clk` edge where `wr_en`=1. `rd_data` shows the new value after that edge.
- Tick latency (SYNC_STAGES=2): if edge E1 is the first to sample `tick_in`=1, TMR0 increments at edge E3. Latency is SYNC_STAGES+1 edges in general.
- `tick_in` high and low phases must each be at least SYNC_STAGES+1 clk periods; shorter pulses may be missed.
- Inhibit: for a TMR0 write at edge W, events landing at edges W+1 through W+INHIBIT_CYCLES are dropped. The first counted increment can land at W+INHIBIT_CYCLES+1.
- `presc_rst_n` is low from edge W to edge W+1.
- `t0if` rises at the overflow edge; `irq` follows in the same cycle.

## Structure
- Package `tmr0_pkg` holds:
  - address constants `ADDR_TMR0`, `ADDR_OPTION`, `ADDR_INTCON`;
  - INTCON bit positions `GIE_BIT`, `T0IE_BIT`, `T0IF_BIT`;
  - `OPTION_RST` = 8'hFF;
  - FSM state enum `{RUN, HOLD}`.
- Sub-module `tmr0_sync_edge` is the parameterised synchroniser plus rising-edge detector, with a synchronous active-low reset.

## Test plan
- Reset with `tick_in` toggling -> `tmr0_val`=0, `rd_data` at OPTION = 8'hFF, `irq`=0, `presc_rst_n`=0 during reset.
- Write TMR0=8'hFD, set GIE and T0IE, then apply 3 tick edges -> counts FE, FF, 00; `t0if`=1 and `irq`=1 at the wrap edge.
- Write TMR0=8'h10 with a tick edge timed to land at W+1 and another at W+3 -> W+1 event dropped; `tmr0_val` becomes 8'h11 at W+3; `presc_rst_n` is low for one cycle.
- Wrap edge coincides with an INTCON write of 8'h00 -> T0IF=1, GIE=0, T0IE=0.
- OPTION write 8'hFF to 8'hFF gives no `presc_rst_n` pulse; OPTION write 8'hF0 gives a one-cycle pulse and `ps`=0, `psa`=0.
- Assert `reset` while in HOLD -> state returns to RUN; the next tick edge counts with normal latency.

Source files
------------

// File: rtl/tmr0_pkg.sv
// rtl/tmr0_pkg.sv - shared constants and state type for the TMR0 register controller
package tmr0_pkg;

    localparam logic [1:0] ADDR_TMR0   = 2'd0;
    localparam logic [1:0] ADDR_OPTION = 2'd1;
    localparam logic [1:0] ADDR_INTCON = 2'd2;

    localparam int GIE_BIT  = 7;
    localparam int T0IE_BIT = 5;
    localparam int T0IF_BIT = 2;

    localparam logic [7:0] OPTION_RST = 8'hFF;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } tmr0_state_e;

endpackage

// File: rtl/tmr0_sync_edge.sv
// rtl/tmr0_sync_edge.sv - multi-flop synchroniser with rising-edge event output
module tmr0_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    // One event per synchronised rising edge; falling edges produce nothing.
    assign o_event = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/tmr0_ctrl.sv
// rtl/tmr0_ctrl.sv - TMR0 count, OPTION/INTCON timer bits and prescaler clear control
module tmr0_ctrl
    import tmr0_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int INHIBIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic       tick_in,
    output logic       t0cs,
    output logic       t0se,
    output logic       psa,
    output logic [2:0] ps,
    output logic       presc_rst_n,
    output logic [7:0] tmr0_val,
    output logic       t0if,
    output logic       irq
);

    localparam int CW = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);

    logic [7:0]    r_option;
    logic [7:0]    r_tmr0;
    logic          r_gie;
    logic          r_t0ie;
    logic          r_t0if;
    logic          r_presc_rst_n;
    tmr0_state_e   r_state;
    logic [CW-1:0] r_inh_cnt;

    logic w_event;
    logic w_wr_tmr0;
    logic w_wr_option;
    logic w_wr_intcon;
    logic w_inc;
    logic w_ovf;

    tmr0_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_async(tick_in),
        .o_event(w_event)
    );

    assign w_wr_tmr0   = wr_en && (addr == ADDR_TMR0);
    assign w_wr_option = wr_en && (addr == ADDR_OPTION);
    assign w_wr_intcon = wr_en && (addr == ADDR_INTCON);

    // A software write to TMR0 always beats a coincident tick.
    assign w_inc = w_event && (r_state == RUN) && !w_wr_tmr0;
    assign w_ovf = w_inc && (r_tmr0 == 8'hFF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmr0    <= 8'h00;
            r_state   <= RUN;
            r_inh_cnt <= '0;
        end else if (w_wr_tmr0) begin
            r_tmr0    <= wr_data;
            r_state   <= HOLD;
            r_inh_cnt <= CW'(INHIBIT_CYCLES);
        end else begin
            case (r_state)
                RUN: begin
                    if (w_inc) r_tmr0 <= r_tmr0 + 8'd1;
                end
                HOLD: begin
                    r_inh_cnt <= r_inh_cnt - 1'b1;
                    if (r_inh_cnt <= CW'(1)) begin
                        r_state   <= RUN;
                        r_inh_cnt <= '0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_option      <= OPTION_RST;
            r_gie         <= 1'b0;
            r_t0ie        <= 1'b0;
            r_t0if        <= 1'b0;
            r_presc_rst_n <= 1'b0;
        end else begin
            // Only a change to the prescaler assignment or ratio disturbs the prescaler.
            r_presc_rst_n <= ~(w_wr_tmr0 ||
                               (w_wr_option && (wr_data[3:0] != r_option[3:0])));
            if (w_wr_option) r_option <= wr_data;
            if (w_wr_intcon) begin
                r_gie  <= wr_data[GIE_BIT];
                r_t0ie <= wr_data[T0IE_BIT];
                r_t0if <= wr_data[T0IF_BIT] | w_ovf;
            end else if (w_ovf) begin
                r_t0if <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_TMR0:   rd_data = r_tmr0;
            ADDR_OPTION: rd_data = r_option;
            ADDR_INTCON: begin
                rd_data[GIE_BIT]  = r_gie;
                rd_data[T0IE_BIT] = r_t0ie;
                rd_data[T0IF_BIT] = r_t0if;
            end
            default:     rd_data = 8'h00;
        endcase
    end

    assign t0cs        = r_option[5];
    assign t0se        = r_option[4];
    assign psa         = r_option[3];
    assign ps          = r_option[2:0];
    assign presc_rst_n = r_presc_rst_n;
    assign tmr0_val    = r_tmr0;
    assign t0if        = r_t0if;
    assign irq         = r_t0if & r_t0ie & r_gie;

endmodule

// File: tb/tb_tmr0_ctrl.sv
// tb/tb_tmr0_ctrl.sv - directed self-checking bench for tmr0_ctrl
module tb_tmr0_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       tick_in;
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
    logic       presc_rst_n;
    logic [7:0] tmr0_val;
    logic       t0if;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    tmr0_ctrl #(
        .SYNC_STAGES   (2),
        .INHIBIT_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .tick_in    (tick_in),
        .t0cs       (t0cs),
        .t0se       (t0se),
        .psa        (psa),
        .ps         (ps),
        .presc_rst_n(presc_rst_n),
        .tmr0_val   (tmr0_val),
        .t0if       (t0if),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Raise tick, check the count three edges later, then drop it for three edges.
    task automatic tick_pulse(input string tag, input logic [7:0] exp);
        tick_in = 1'b1;
        cyc(2);
        chk({tag, "_pre"}, tmr0_val, exp - 8'd1);
        cyc(1);
        chk(tag, tmr0_val, exp);
        tick_in = 1'b0;
        cyc(3);
    endtask

    initial begin
        reset   = 1'b0;
        addr    = 2'd0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tick_in = 1'b0;

        // Reset with tick toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
        end
        cyc(1);
        addr = 2'd1;
        #1;
        chk("rst_tmr0", tmr0_val, 8'h00);
        chk("rst_option", rd_data, 8'hFF);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_presc", {7'd0, presc_rst_n}, 8'h00);
        chk("rst_cfg", {2'd0, t0cs, t0se, psa, ps}, 8'h3F);
        tick_in = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("presc_idle", {7'd0, presc_rst_n}, 8'h01);
        addr = 2'd3;
        #1;
        chk("unmapped_rd", rd_data, 8'h00);

        // Count through the wrap with interrupts enabled
        wr(2'd0, 8'hFD);
        chk("wr_fd", tmr0_val, 8'hFD);
        chk("wr_fd_presc", {7'd0, presc_rst_n}, 8'h00);
        cyc(1);
        chk("wr_fd_presc_end", {7'd0, presc_rst_n}, 8'h01);
        wr(2'd2, 8'hA0);
        addr = 2'd2;
        #1;
        chk("intcon_rd", rd_data, 8'hA0);
        tick_pulse("cnt_fe", 8'hFE);
        tick_pulse("cnt_ff", 8'hFF);
        chk("t0if_before_wrap", {7'd0, t0if}, 8'h00);
        tick_in = 1'b1;
        cyc(3);
        chk("wrap_00", tmr0_val, 8'h00);
        chk("wrap_t0if", {7'd0, t0if}, 8'h01);
        chk("wrap_irq", {7'd0, irq}, 8'h01);
        tick_in = 1'b0;
        cyc(3);
        wr(2'd2, 8'hA0);
        chk("t0if_clr", {7'd0, t0if}, 8'h00);
        chk("irq_clr", {7'd0, irq}, 8'h00);

        // TMR0 write W with tick events landing at W+1 (dropped) and W+3 (counted)
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        addr    = 2'd0;
        wr_data = 8'h10;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        tick_in = 1'b1;
        chk("inh_w", tmr0_val, 8'h10);
        chk("inh_presc_lo", {7'd0, presc_rst_n}, 8'h00);
        cyc(1);
        chk("inh_w1_drop", tmr0_val, 8'h10);
        chk("inh_presc_hi", {7'd0, presc_rst_n}, 8'h01);
        cyc(1);
        chk("inh_w2", tmr0_val, 8'h10);
        cyc(1);
        chk("inh_w3_count", tmr0_val, 8'h11);
        tick_in = 1'b0;
        cyc(4);

        // Wrap coincides with an INTCON write of zero: set wins for T0IF
        wr(2'd0, 8'hFF);
        cyc(3);
        tick_in = 1'b1;
        cyc(2);
        addr    = 2'd2;
        wr_data = 8'h00;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        chk("coll_tmr0", tmr0_val, 8'h00);
        chk("coll_t0if", {7'd0, t0if}, 8'h01);
        chk("coll_intcon", rd_data, 8'h04);
        chk("coll_irq", {7'd0, irq}, 8'h00);
        tick_in = 1'b0;
        cyc(3);

        // OPTION writes
        wr(2'd1, 8'hFF);
        chk("opt_same_presc", {7'd0, presc_rst_n}, 8'h01);
        wr(2'd1, 8'hF0);
        chk("opt_chg_presc", {7'd0, presc_rst_n}, 8'h00);
        chk("opt_cfg", {2'd0, t0cs, t0se, psa, ps}, 8'h30);
        addr = 2'd1;
        #1;
        chk("opt_rd", rd_data, 8'hF0);
        cyc(1);
        chk("opt_presc_end", {7'd0, presc_rst_n}, 8'h01);

        // Reset while in HOLD
        wr(2'd0, 8'h55);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("hold_rst_tmr0", tmr0_val, 8'h00);
        chk("hold_rst_t0if", {7'd0, t0if}, 8'h00);
        chk("hold_rst_presc", {7'd0, presc_rst_n}, 8'h00);
        tick_pulse("hold_rst_cnt", 8'h01);

        // Software sets T0IF
        wr(2'd2, 8'h24);
        chk("sw_set_t0if", {7'd0, t0if}, 8'h01);
        chk("sw_set_irq_off", {7'd0, irq}, 8'h00);
        wr(2'd2, 8'hA4);
        chk("sw_set_irq_on", {7'd0, irq}, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
